onehot_rr_arbiter: RTL and testbench

//  Round-robin arbiter: shares one resource among N requesters via a registered grant

---
 rtl/onehot_rr_arbiter_pkg.sv | 18 +
 rtl/onehot_rr_arbiter_if.sv | 25 ++
 rtl/onehot_rr_arbiter_pick.sv | 34 +++
 rtl/onehot_rr_arbiter.sv | 110 +++++++++++
 tb/tb_onehot_rr_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/onehot_rr_arbiter_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
// Exports: arb_state_e (IDLE/GRANT), default sizes, next_idx().
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   localparam int ARB_N        = 5;
   localparam int ARB_MAX_HOLD = 8;

   // Modulo-n increment; n need not be a power of two.
   function automatic int next_idx(input int ptr, input int n);
      return (ptr >= n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// master: drives req, sees grant; slave: the arbiter side.
interface onehot_rr_arbiter_if #(
   parameter int N = 5
);

   localparam int IDX_W = $clog2(N);

   logic [N-1:0]     req;
   logic [N-1:0]     gnt;
   logic             gnt_valid;
   logic [IDX_W-1:0] gnt_idx;
   logic             timeout;

   modport master (
      output req,
      input  gnt, gnt_valid, gnt_idx, timeout
   );

   modport slave (
      input  req,
      output gnt, gnt_valid, gnt_idx, timeout
   );

endinterface

// File: rtl/onehot_rr_arbiter_pick.sv
// Combinational round-robin picker: first set req bit after ptr.
// In: req[N], ptr. Out: pick_oh (one-hot/0), pick_idx, pick_vld.
module rr_pick #(
   parameter  int N     = 5,
   localparam int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     pick_oh,
   output logic [IDX_W-1:0] pick_idx,
   output logic             pick_vld
);

   import arb_pkg::*;

   logic [IDX_W-1:0] cur;

   // Visit ptr+1, ptr+2, ... wrapping; ptr itself is tried last.
   always_comb begin
      pick_oh  = '0;
      pick_idx = '0;
      pick_vld = 1'b0;
      cur      = ptr;
      for (int k = 0; k < N; k++) begin
         cur = IDX_W'(next_idx(int'(cur), N));
         if (!pick_vld && req[cur]) begin
            pick_vld     = 1'b1;
            pick_oh[cur] = 1'b1;
            pick_idx     = cur;
         end
      end
   end

endmodule

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and hold limit.
// Ports: clk, rst (async high), bus (slave: req in; gnt/valid/idx/timeout out).
module onehot_rr_arbiter #(
   parameter int N        = 5,
   parameter int MAX_HOLD = 8
) (
   input logic                 clk,
   input logic                 rst,
   onehot_rr_arbiter_if.slave  bus
);

   import arb_pkg::*;

   localparam int IDX_W = $clog2(N);
   localparam int CNT_W = $clog2(MAX_HOLD + 1);

   localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(N - 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

   arb_state_e       state;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] hold_cnt;
   logic [N-1:0]     gnt_q;
   logic             vld_q;
   logic [IDX_W-1:0] idx_q;
   logic             to_q;

   logic [N-1:0]     pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_vld;
   logic             own_req;

   rr_pick #(.N(N)) u_pick (
      .req      (bus.req),
      .ptr      (ptr),
      .pick_oh  (pick_oh),
      .pick_idx (pick_idx),
      .pick_vld (pick_vld)
   );

   // ptr always names the current (or last) owner.
   assign own_req = bus.req[ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= PTR_RST;
         hold_cnt <= '0;
         gnt_q    <= '0;
         vld_q    <= 1'b0;
         idx_q    <= '0;
         to_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               to_q <= 1'b0;
               if (pick_vld) begin
                  state    <= GRANT;
                  ptr      <= pick_idx;
                  hold_cnt <= CNT_W'(1);
                  gnt_q    <= pick_oh;
                  vld_q    <= 1'b1;
                  idx_q    <= pick_idx;
               end else begin
                  hold_cnt <= '0;
                  gnt_q    <= '0;
                  vld_q    <= 1'b0;
                  idx_q    <= '0;
               end
            end
            GRANT: begin
               if (own_req && hold_cnt < HOLD_MAX) begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
                  to_q     <= 1'b0;
               end else begin
                  // Release always passes through IDLE: one bubble.
                  state    <= IDLE;
                  hold_cnt <= '0;
                  gnt_q    <= '0;
                  vld_q    <= 1'b0;
                  idx_q    <= '0;
                  to_q     <= own_req;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = vld_q;
   assign bus.gnt_idx   = idx_q;
   assign bus.timeout   = to_q;

   a_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(gnt_q));
   a_count1: assert property (@(posedge clk) disable iff (rst)
      vld_q |-> $countones(gnt_q) == 1);
   a_vld: assert property (@(posedge clk) disable iff (rst)
      vld_q == (gnt_q != '0));
   a_idx: assert property (@(posedge clk) disable iff (rst)
      vld_q |-> gnt_q[idx_q]);
   a_to: assert property (@(posedge clk) disable iff (rst)
      to_q |-> !vld_q);
   a_req_known: assert property (@(posedge clk) disable iff (rst)
      !$isunknown(bus.req));

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed and random checks for onehot_rr_arbiter (N=5, MAX_HOLD 8 and 1).
// Prints one summary line: passed/total.
module tb_onehot_rr_arbiter;

   localparam int N = 5;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_tot;

   onehot_rr_arbiter_if #(.N(N)) b ();
   onehot_rr_arbiter_if #(.N(N)) b1 ();

   onehot_rr_arbiter #(.N(N), .MAX_HOLD(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   onehot_rr_arbiter #(.N(N), .MAX_HOLD(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] gnt;
      logic [2:0]   idx;
      logic         to;
   } vec_t;

   vec_t vt [17];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string nm, input logic [N-1:0] g,
                          input logic [2:0] i, input logic t);
      chk({nm, ".gnt"}, 32'(b.gnt), 32'(g));
      chk({nm, ".vld"}, 32'(b.gnt_valid), 32'(g != '0));
      chk({nm, ".idx"}, 32'(b.gnt_idx), 32'(i));
      chk({nm, ".to"}, 32'(b.timeout), 32'(t));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   int cnt [N];
   logic prev_v;

   initial begin
      n_pass = 0;
      n_tot  = 0;
      b.req  = '0;
      b1.req = '0;
      rst    = 1'b1;

      // Reset held with all requesting: no grant.
      b.req = 5'b11111;
      step();
      step();
      chk_out("rst_hold", 5'b00000, 3'd0, 1'b0);
      rst = 1'b0;

      //        req       gnt       idx   to
      vt[0]  = '{5'b11111, 5'b00001, 3'd0, 1'b0};
      vt[1]  = '{5'b00000, 5'b00000, 3'd0, 1'b0};
      vt[2]  = '{5'b01000, 5'b01000, 3'd3, 1'b0};
      vt[3]  = '{5'b01000, 5'b01000, 3'd3, 1'b0};
      vt[4]  = '{5'b01000, 5'b01000, 3'd3, 1'b0};
      vt[5]  = '{5'b00000, 5'b00000, 3'd0, 1'b0};
      vt[6]  = '{5'b10000, 5'b10000, 3'd4, 1'b0};
      vt[7]  = '{5'b00011, 5'b00000, 3'd0, 1'b0};
      vt[8]  = '{5'b00011, 5'b00001, 3'd0, 1'b0};
      vt[9]  = '{5'b00010, 5'b00000, 3'd0, 1'b0};
      vt[10] = '{5'b00010, 5'b00010, 3'd1, 1'b0};
      vt[11] = '{5'b00011, 5'b00010, 3'd1, 1'b0};
      vt[12] = '{5'b00001, 5'b00000, 3'd0, 1'b0};
      vt[13] = '{5'b00001, 5'b00001, 3'd0, 1'b0};
      vt[14] = '{5'b00000, 5'b00000, 3'd0, 1'b0};
      vt[15] = '{5'b00001, 5'b00001, 3'd0, 1'b0};
      vt[16] = '{5'b00000, 5'b00000, 3'd0, 1'b0};

      for (int i = 0; i < 17; i++) begin
         b.req = vt[i].req;
         step();
         chk_out($sformatf("vec%0d", i), vt[i].gnt, vt[i].idx, vt[i].to);
      end

      // Two contenders: strict alternation, each hold MAX_HOLD.
      do_reset();
      b.req = 5'b10100;
      for (int rep = 0; rep < 3; rep++) begin
         for (int c = 0; c < 8; c++) begin
            step();
            if (rep % 2 == 0)
               chk_out($sformatf("alt%0d_%0d", rep, c), 5'b00100, 3'd2, 1'b0);
            else
               chk_out($sformatf("alt%0d_%0d", rep, c), 5'b10000, 3'd4, 1'b0);
         end
         if (rep < 2) begin
            step();
            chk_out($sformatf("alt%0d_to", rep), 5'b00000, 3'd0, 1'b1);
         end
      end

      // Async reset mid-grant, then priority restart.
      do_reset();
      b.req = 5'b00100;
      step();
      chk_out("mid_pre", 5'b00100, 3'd2, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      chk_out("mid_async", 5'b00000, 3'd0, 1'b0);
      step();
      rst = 1'b0;
      step();
      chk_out("mid_regrant", 5'b00100, 3'd2, 1'b0);
      b.req = 5'b11011;
      step();
      chk_out("mid_rel", 5'b00000, 3'd0, 1'b0);
      step();
      chk_out("mid_next", 5'b01000, 3'd3, 1'b0);

      // MAX_HOLD=1 instance: one-cycle grants with timeout pulses.
      b.req = '0;
      do_reset();
      b1.req = 5'b00001;
      step();
      chk("mh1_g0", 32'(b1.gnt), 32'(5'b00001));
      chk("mh1_t0", 32'(b1.timeout), 32'd0);
      step();
      chk("mh1_g1", 32'(b1.gnt), 32'd0);
      chk("mh1_t1", 32'(b1.timeout), 32'd1);
      step();
      chk("mh1_g2", 32'(b1.gnt), 32'(5'b00001));
      b1.req = 5'b00011;
      step();
      chk("mh1_t3", 32'(b1.timeout), 32'd1);
      step();
      chk("mh1_g4", 32'(b1.gnt), 32'(5'b00010));
      chk("mh1_i4", 32'(b1.gnt_idx), 32'd1);
      b1.req = '0;
      step();
      chk("mh1_g5", 32'(b1.gnt), 32'd0);
      chk("mh1_t5", 32'(b1.timeout), 32'd0);

      // Fairness: all request continuously, 20 ownerships of 9 cycles.
      do_reset();
      for (int i = 0; i < N; i++) cnt[i] = 0;
      prev_v = 1'b0;
      b.req  = 5'b11111;
      for (int c = 0; c < 180; c++) begin
         step();
         if (b.gnt_valid && !prev_v) cnt[b.gnt_idx]++;
         prev_v = b.gnt_valid;
      end
      begin
         int mx, mn, tot;
         mx  = cnt[0];
         mn  = cnt[0];
         tot = 0;
         for (int i = 0; i < N; i++) begin
            if (cnt[i] > mx) mx = cnt[i];
            if (cnt[i] < mn) mn = cnt[i];
            tot += cnt[i];
         end
         chk("fair_spread", 32'(mx - mn <= 1), 32'd1);
         chk("fair_total", 32'(tot), 32'd20);
      end

      // Random 2-state requests: output invariants every cycle.
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         b.req = N'($urandom_range(0, 31));
         step();
         chk("inv_oh", 32'($onehot0(b.gnt)), 32'd1);
         chk("inv_vld", 32'(b.gnt_valid), 32'(b.gnt != '0));
         if (b.gnt_valid)
            chk("inv_idx", 32'(b.gnt[b.gnt_idx]), 32'd1);
         if (b.timeout)
            chk("inv_to", 32'(b.gnt_valid), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
